// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade cabinet-input front end: joystick bit map,
// sys output layout and the default OSD download index for DIP switches.
package arcade_input_pkg;

  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_BTN1  = 4;
  localparam int JOY_START = 8;
  localparam int JOY_COIN  = 9;

  localparam int NUM_BTNS    = 4;
  localparam int MAX_PLAYERS = 4;

  localparam int SYS_COIN  = 0;
  localparam int SYS_START = 4;

  localparam logic [7:0] DIP_INDEX_DEFAULT = 8'd254;

endpackage

// File: rtl/coin_stretch.sv
// Per-player coin stretcher: a rising edge on coin_i while idle produces an
// active-low registered pulse exactly COIN_PULSE cycles wide.
module coin_stretch #(
  parameter int COIN_PULSE = 4096
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic coin_i,
  output logic coin_n_o
);

  localparam int CW = $clog2(COIN_PULSE + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_q;
  logic          coin_n_q;

  // Edges seen while a pulse is running are dropped, not queued.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else if (coin_i && !prev_q) begin
      cnt_d = CW'(COIN_PULSE);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      prev_q   <= 1'b0;
      coin_n_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      prev_q   <= coin_i;
      coin_n_q <= (cnt_d == '0);
    end
  end

  assign coin_n_o = coin_n_q;

endmodule

// File: rtl/arcade_input_ctrl.sv
// Cabinet-input front end between hps_io and a game core: DIP capture from
// OSD downloads, active-low player/system ports, coin stretching and autofire.
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int                      NUM_PLAYERS   = 2,
  parameter int                      DIP_BYTES     = 2,
  parameter logic [7:0]              DIP_INDEX     = DIP_INDEX_DEFAULT,
  parameter logic [DIP_BYTES*8-1:0]  DIP_DEFAULT   = '1,
  parameter logic [15:0]             COIN_PULSE    = 16'd4096,
  parameter logic [19:0]             AUTOFIRE_DIV  = 20'd400000,
  parameter logic [3:0]              AUTOFIRE_MASK = 4'b0001
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic [NUM_PLAYERS*16-1:0]  joy,
  input  logic                       autofire_en,
  input  logic                       ioctl_wr,
  input  logic [7:0]                 ioctl_index,
  input  logic [26:0]                ioctl_addr,
  input  logic [15:0]                ioctl_dout,
  output logic [DIP_BYTES*8-1:0]     dsw,
  output logic [NUM_PLAYERS*8-1:0]   player,
  output logic [7:0]                 sys
);

  localparam int DSW_W   = DIP_BYTES * 8;
  localparam int ADDR_SH = $clog2(DIP_BYTES);
  localparam int BANK_W  = (ADDR_SH > 0) ? ADDR_SH : 1;
  localparam int AFW     = $clog2(AUTOFIRE_DIV);

  logic [DSW_W-1:0]         dsw_q, dsw_d;
  logic [NUM_PLAYERS*8-1:0] player_q, player_d;
  logic [NUM_PLAYERS-1:0]   start_n_q, start_n_d;
  logic [AFW-1:0]           af_cnt_q, af_cnt_d;
  logic                     af_phase_q, af_phase_d;
  logic                     af_wrap;
  logic [NUM_BTNS-1:0]      af_gate;
  logic [24:0]              addr_lo;
  logic [BANK_W-1:0]        bank_sel;
  logic                     dip_hit;
  logic [MAX_PLAYERS-1:0]   coin_n_w;
  logic [MAX_PLAYERS-1:0]   start_n_w;
  logic [NUM_PLAYERS-1:0]   unused_joy;
  logic                     unused_io;

  assign addr_lo  = ioctl_addr[24:0];
  assign bank_sel = addr_lo[BANK_W-1:0];
  assign dip_hit  = ioctl_wr && (ioctl_index == DIP_INDEX) &&
                    ((addr_lo >> ADDR_SH) == 25'd0);

  always_comb begin
    dsw_d = dsw_q;
    for (int k = 0; k < DIP_BYTES; k++) begin
      if (dip_hit && (bank_sel == BANK_W'(k))) begin
        dsw_d[8*k +: 8] = ioctl_dout[7:0];
      end
    end
  end

  // Free-running autofire timebase shared by every player.
  assign af_wrap    = (af_cnt_q == AFW'(AUTOFIRE_DIV - 20'd1));
  assign af_cnt_d   = af_wrap ? '0 : af_cnt_q + AFW'(1);
  assign af_phase_d = af_phase_q ^ af_wrap;
  assign af_gate    = AUTOFIRE_MASK & {NUM_BTNS{autofire_en}};

  always_comb begin
    player_d   = '1;
    start_n_d  = '1;
    unused_joy = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      player_d[8*p +: 8] = ~{joy[16*p+JOY_BTN1 +: NUM_BTNS] & (~af_gate | {NUM_BTNS{af_phase_q}}),
                             joy[16*p+JOY_UP], joy[16*p+JOY_DOWN],
                             joy[16*p+JOY_LEFT], joy[16*p+JOY_RIGHT]};
      start_n_d[p]  = ~joy[16*p+JOY_START];
      unused_joy[p] = ^joy[16*p+10 +: 6];
    end
  end

  assign unused_io = ^{ioctl_addr[26:25], ioctl_dout[15:8], joy[JOY_COIN], unused_joy};

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      dsw_q      <= DIP_DEFAULT;
      player_q   <= '1;
      start_n_q  <= '1;
      af_cnt_q   <= '0;
      af_phase_q <= 1'b0;
    end else begin
      dsw_q      <= dsw_d;
      player_q   <= player_d;
      start_n_q  <= start_n_d;
      af_cnt_q   <= af_cnt_d;
      af_phase_q <= af_phase_d;
    end
  end

  // Slots for absent players stay released (1).
  for (genvar p = 0; p < MAX_PLAYERS; p++) begin : g_player
    if (p < NUM_PLAYERS) begin : g_on
      coin_stretch #(
        .COIN_PULSE (int'(COIN_PULSE))
      ) u_coin (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .coin_i   (joy[16*p+JOY_COIN]),
        .coin_n_o (coin_n_w[p])
      );
      assign start_n_w[p] = start_n_q[p];
    end else begin : g_off
      assign coin_n_w[p]  = 1'b1;
      assign start_n_w[p] = 1'b1;
    end
  end

  assign dsw    = dsw_q;
  assign player = player_q;
  assign sys    = {start_n_w, coin_n_w};

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Scoreboard bench for arcade_input_ctrl: a cycle model queues expected outputs
// per clock, plus directed checks of DIP capture, mapping, coin and autofire.
module tb_arcade_input_ctrl;

  localparam int CP  = 8;
  localparam int AFD = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [31:0] joy;
  logic        autofire_en;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic [15:0] dsw;
  logic [15:0] player;
  logic [7:0]  sys;

  always #5 clk_sys = ~clk_sys;

  arcade_input_ctrl #(
    .NUM_PLAYERS   (2),
    .DIP_BYTES     (2),
    .DIP_INDEX     (8'd254),
    .DIP_DEFAULT   (16'hFFFF),
    .COIN_PULSE    (16'd8),
    .AUTOFIRE_DIV  (20'd4),
    .AUTOFIRE_MASK (4'b0001)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .joy         (joy),
    .autofire_en (autofire_en),
    .ioctl_wr    (ioctl_wr),
    .ioctl_index (ioctl_index),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .dsw         (dsw),
    .player      (player),
    .sys         (sys)
  );

  typedef struct packed {
    logic [15:0] dsw;
    logic [15:0] player;
    logic [7:0]  sys;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  logic [15:0] m_dsw;
  logic [15:0] m_player;
  logic [7:0]  m_sys;
  int          m_cnt[2];
  bit          m_prev[2];
  int          m_af;
  bit          m_ph;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour for one clk_sys edge given the inputs now driven.
  task automatic model_step();
    logic [7:0] pr;
    if (!reset_n) begin
      m_dsw    = 16'hFFFF;
      m_player = 16'hFFFF;
      m_sys    = 8'hFF;
      m_cnt[0] = 0; m_cnt[1] = 0;
      m_prev[0] = 1'b0; m_prev[1] = 1'b0;
      m_af = 0;
      m_ph = 1'b0;
    end else begin
      if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr[24:1] == 24'd0) begin
        if (ioctl_addr[0]) m_dsw[15:8] = ioctl_dout[7:0];
        else               m_dsw[7:0]  = ioctl_dout[7:0];
      end
      for (int p = 0; p < 2; p++) begin
        pr = joy[16*p +: 8];
        if (autofire_en && !m_ph) pr[4] = 1'b0;
        m_player[8*p +: 8] = ~pr;
        m_sys[4+p] = ~joy[16*p+8];
        if (m_cnt[p] != 0) m_cnt[p] = m_cnt[p] - 1;
        else if (joy[16*p+9] && !m_prev[p]) m_cnt[p] = CP;
        m_prev[p] = joy[16*p+9];
        m_sys[p] = (m_cnt[p] == 0);
      end
      m_sys[3:2] = 2'b11;
      m_sys[7:6] = 2'b11;
      if (m_af == AFD - 1) begin
        m_af = 0;
        m_ph = !m_ph;
      end else begin
        m_af = m_af + 1;
      end
    end
  endtask

  task automatic cycle();
    exp_t e;
    model_step();
    e = '{dsw: m_dsw, player: m_player, sys: m_sys};
    sb.push_back(e);
    @(posedge clk_sys);
    #1;
    e = sb.pop_front();
    chk("sb_dsw", dsw, e.dsw);
    chk("sb_player", player, e.player);
    chk("sb_sys", sys, e.sys);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    int lows;
    int last;
    logic s_prev;
    reset_n     = 1'b0;
    joy         = '0;
    autofire_en = 1'b0;
    ioctl_wr    = 1'b0;
    ioctl_index = '0;
    ioctl_addr  = '0;
    ioctl_dout  = '0;

    run(3);
    chk("rst_dsw", dsw, 16'hFFFF);
    chk("rst_player", player, 16'hFFFF);
    chk("rst_sys", sys, 8'hFF);
    reset_n = 1'b1;
    run(2);

    ioctl_wr = 1'b1; ioctl_index = 8'd254; ioctl_addr = 27'd1; ioctl_dout = 16'h00A5;
    cycle();
    ioctl_wr = 1'b0;
    chk("dip_bank1", dsw, 16'hA5FF);
    ioctl_wr = 1'b1; ioctl_index = 8'd0; ioctl_addr = 27'd1; ioctl_dout = 16'h0011;
    cycle();
    ioctl_index = 8'd254; ioctl_addr = 27'd2; ioctl_dout = 16'h0022;
    cycle();
    ioctl_wr = 1'b0;
    chk("dip_ignore", dsw, 16'hA5FF);
    ioctl_wr = 1'b1; ioctl_addr = 27'd0; ioctl_dout = 16'hFF3C;
    cycle();
    ioctl_wr = 1'b0;
    chk("dip_bank0", dsw, 16'hA53C);

    joy = 32'h0000_0019;
    cycle();
    chk("map_p0", player[7:0], 8'hE6);
    chk("start_off", sys[4], 1'b1);
    joy = 32'h0000_0119;
    cycle();
    chk("start_on", sys[4], 1'b0);
    joy = 32'h0180_0000;
    cycle();
    chk("map_p1", player[15:8], 8'h7F);
    chk("start_p1", sys[5], 1'b0);
    joy = '0;
    run(2);

    lows = 0;
    for (int i = 0; i < 12; i++) begin
      joy[9] = (i == 0);
      cycle();
      if (i == 0) chk("coin_start", sys[0], 1'b0);
      if (sys[0] == 1'b0) lows++;
    end
    chk("coin_width", lows, CP);

    lows = 0;
    for (int i = 0; i < 16; i++) begin
      joy[9] = (i == 0 || i == 3);
      cycle();
      if (sys[0] == 1'b0) lows++;
    end
    chk("coin_noext", lows, CP);

    lows = 0;
    for (int i = 0; i < 30; i++) begin
      joy[9] = (i < 20);
      cycle();
      if (sys[0] == 1'b0) lows++;
    end
    chk("coin_hold", lows, CP);

    lows = 0;
    for (int i = 0; i < 12; i++) begin
      joy[25] = (i == 0);
      cycle();
      if (sys[1] == 1'b0) lows++;
    end
    chk("coin_p1", lows, CP);

    autofire_en = 1'b1;
    joy = 32'h0000_0010;
    cycle();
    lows = 0;
    last = -1;
    s_prev = player[4];
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (player[4] == 1'b0) lows++;
      if (i > 0 && player[4] != s_prev) begin
        if (last >= 0) chk("af_period", i - last, AFD);
        last = i;
      end
      s_prev = player[4];
    end
    chk("af_duty", lows, 8);

    joy = 32'h0000_0020;
    cycle();
    lows = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (player[5] == 1'b0) lows++;
    end
    chk("af_unmasked", lows, 8);

    autofire_en = 1'b0;
    joy = 32'h0000_0010;
    cycle();
    lows = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (player[4] == 1'b0) lows++;
    end
    chk("af_off", lows, 8);

    for (int i = 0; i < 60; i++) begin
      joy         = $urandom & 32'h03FF_03FF;
      autofire_en = 1'($urandom);
      ioctl_wr    = 1'($urandom);
      ioctl_index = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'd254;
      ioctl_addr  = ($urandom_range(0, 3) == 0) ? 27'($urandom) : 27'($urandom_range(0, 3));
      ioctl_dout  = 16'($urandom);
      cycle();
    end

    joy = '0; autofire_en = 1'b0; ioctl_wr = 1'b0;
    run(12);
    joy[9] = 1'b1;
    cycle();
    joy[9] = 1'b0;
    run(2);
    chk("coin_mid", sys[0], 1'b0);
    reset_n = 1'b0;
    cycle();
    chk("rst_coin", sys[0], 1'b1);
    chk("rst_dsw2", dsw, 16'hFFFF);
    reset_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (sys[0] == 1'b0) lows++;
    end
    chk("no_resume", lows, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
